// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// mips_isa_pkg
// MIPS32 opcode/field constants and the per-instruction issue decode record.
// Revision: 1.0
// ============================================================================
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef struct packed {
    logic       has_dst;
    logic [4:0] dst;
    logic       rs_used;
    logic       rt_used;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mem;
    logic       load;
    logic       br;
  } dec_t;

  // True when the decoded instruction sources register r.
  function automatic logic reads_reg(input dec_t d, input logic [4:0] r);
    return (d.rs_used && (d.rs == r)) || (d.rt_used && (d.rt == r));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_issue_decode.sv
`default_nettype none
// ============================================================================
// mips_issue_decode
// Combinational register-usage / class decode of one instruction for issue.
// Revision: 1.0
// ============================================================================
module mips_issue_decode
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic       unused_funct;

  assign op           = instr_i[OP_MSB:OP_LSB];
  assign unused_funct = ^instr_i[RD_LSB-1:0];

  always_comb begin
    dec_o    = '0;
    dec_o.rs = instr_i[RS_MSB:RS_LSB];
    dec_o.rt = instr_i[RT_MSB:RT_LSB];
    case (op)
      OP_RTYPE: begin
        dec_o.has_dst = 1'b1;
        dec_o.dst     = instr_i[RD_MSB:RD_LSB];
        dec_o.rs_used = 1'b1;
        dec_o.rt_used = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec_o.has_dst = 1'b1;
        dec_o.dst     = instr_i[RT_MSB:RT_LSB];
        dec_o.rs_used = 1'b1;
      end
      OP_LW: begin
        dec_o.has_dst = 1'b1;
        dec_o.dst     = instr_i[RT_MSB:RT_LSB];
        dec_o.rs_used = 1'b1;
        dec_o.mem     = 1'b1;
        dec_o.load    = 1'b1;
      end
      OP_SW: begin
        dec_o.rs_used = 1'b1;
        dec_o.rt_used = 1'b1;
        dec_o.mem     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.rs_used = 1'b1;
        dec_o.rt_used = 1'b1;
        dec_o.br      = 1'b1;
      end
      OP_J: begin
        dec_o.br = 1'b1;
      end
      default: ;
    endcase
    // Writes to $zero never create a hazard.
    if (dec_o.dst == 5'd0) begin
      dec_o.has_dst = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// dual_issue_scheduler
// Pair queue between fetch and two decode lanes; in-order 0/1/2 issue per cycle.
// Revision: 1.0
// ============================================================================
module dual_issue_scheduler
  import mips_isa_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int PTRW   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr0,
  input  logic [31:0] fetch_instr1,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        issue_ready,
  output logic        issue0_valid,
  output logic [31:0] issue0_instr,
  output logic [31:0] issue0_pc,
  output logic        issue1_valid,
  output logic [31:0] issue1_instr,
  output logic [31:0] issue1_pc,
  input  logic        flush
);

  localparam logic [PTRW:0] PUSH_LIMIT = (PTRW+1)'(QDEPTH - 2);
  localparam logic [PTRW:0] CNT_TWO    = (PTRW+1)'(2);

  logic [31:0]     instr_q [QDEPTH];
  logic [31:0]     pc_q    [QDEPTH];
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [PTRW:0]   count_q, count_d, push_cnt, pop_cnt;
  logic            lu_valid_q, lu_valid_d;
  logic [4:0]      lu_reg_q, lu_reg_d;

  dec_t dec0, dec1;
  logic lu_hit0, lu_hit1, pair_ok, v0, v1, push;
  logic unused_br0;

  assign head1 = head_q + PTRW'(1);
  assign tail1 = tail_q + PTRW'(1);

  mips_issue_decode u_dec0 (.instr_i(instr_q[head_q]), .dec_o(dec0));
  mips_issue_decode u_dec1 (.instr_i(instr_q[head1]),  .dec_o(dec1));

  // A branch in slot 0 is legal, so its branch flag is never consulted.
  assign unused_br0 = dec0.br;

  assign lu_hit0 = lu_valid_q && reads_reg(dec0, lu_reg_q);
  assign lu_hit1 = lu_valid_q && reads_reg(dec1, lu_reg_q);

  assign pair_ok = !(dec0.has_dst && reads_reg(dec1, dec0.dst))
                && !(dec0.has_dst && dec1.has_dst && (dec0.dst == dec1.dst))
                && !(dec0.mem && dec1.mem)
                && !dec1.br;

  assign v0 = (count_q != '0) && !flush && !lu_hit0;
  assign v1 = v0 && (count_q >= CNT_TWO) && !lu_hit1 && pair_ok;

  assign fetch_ready = (count_q <= PUSH_LIMIT);
  assign push        = fetch_valid && fetch_ready && !flush;

  assign push_cnt = push ? CNT_TWO : '0;
  assign pop_cnt  = issue_ready ? ({{PTRW{1'b0}}, v0} + {{PTRW{1'b0}}, v1}) : '0;

  assign issue0_valid = v0;
  assign issue1_valid = v1;
  assign issue0_instr = v0 ? instr_q[head_q] : 32'd0;
  assign issue0_pc    = v0 ? pc_q[head_q]    : 32'd0;
  assign issue1_instr = v1 ? instr_q[head1]  : 32'd0;
  assign issue1_pc    = v1 ? pc_q[head1]     : 32'd0;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    lu_valid_d = lu_valid_q;
    lu_reg_d   = lu_reg_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      lu_valid_d = 1'b0;
    end else begin
      head_d  = head_q + pop_cnt[PTRW-1:0];
      count_d = count_q + push_cnt - pop_cnt;
      if (push) begin
        tail_d = tail_q + PTRW'(2);
      end
      // The youngest load issued this cycle owns the load-use window.
      if (issue_ready) begin
        if (v1 && dec1.load) begin
          lu_valid_d = (dec1.rt != 5'd0);
          lu_reg_d   = dec1.rt;
        end else if (v0 && dec0.load) begin
          lu_valid_d = (dec0.rt != 5'd0);
          lu_reg_d   = dec0.rt;
        end else begin
          lu_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      lu_valid_q <= 1'b0;
      lu_reg_q   <= 5'd0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      lu_valid_q <= lu_valid_d;
      lu_reg_q   <= lu_reg_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by the valids.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q] <= fetch_instr0;
      pc_q[tail_q]    <= fetch_pc;
      instr_q[tail1]  <= fetch_instr1;
      pc_q[tail1]     <= fetch_pc + 32'd4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dual_issue_scheduler
// Directed stimulus with an issue scoreboard for dual_issue_scheduler.
// Revision: 1.0
// ============================================================================
module tb_dual_issue_scheduler;

  localparam logic [31:0] ADD3  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] ADD7  = 32'h00A63820;  // add $7,$5,$6
  localparam logic [31:0] ADD5  = 32'h00642820;  // add $5,$3,$4
  localparam logic [31:0] LW2   = 32'h8C220000;  // lw  $2,0($1)
  localparam logic [31:0] SW3   = 32'hAC230004;  // sw  $3,4($1)
  localparam logic [31:0] ADDU2 = 32'h00431820;  // add $3,$2,$3
  localparam logic [31:0] BEQ   = 32'h10220003;  // beq $1,$2,+3
  localparam logic [31:0] NOP   = 32'h00000000;
  localparam logic [31:0] ADD9  = 32'h00E84820;  // add $9,$7,$8
  localparam logic [31:0] ADD10 = 32'h016C5020;  // add $10,$11,$12

  logic        clk, rst_n;
  logic        fetch_valid, fetch_ready, issue_ready, flush;
  logic [31:0] fetch_instr0, fetch_instr1, fetch_pc;
  logic        issue0_valid, issue1_valid;
  logic [31:0] issue0_instr, issue0_pc, issue1_instr, issue1_pc;

  typedef struct packed {
    logic        slot;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  dual_issue_scheduler #(.QDEPTH(4), .PTRW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_instr0 (fetch_instr0),
    .fetch_instr1 (fetch_instr1),
    .fetch_pc     (fetch_pc),
    .fetch_ready  (fetch_ready),
    .issue_ready  (issue_ready),
    .issue0_valid (issue0_valid),
    .issue0_instr (issue0_instr),
    .issue0_pc    (issue0_pc),
    .issue1_valid (issue1_valid),
    .issue1_instr (issue1_instr),
    .issue1_pc    (issue1_pc),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic check_issue(input logic slot, input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_issue: slot%0d instr 0x%08h pc 0x%08h, expected nothing", slot, instr, pc);
    end else begin
      e = exp_q.pop_front();
      if (e.slot === slot && e.instr === instr && e.pc === pc) n_pass++;
      else $display("FAIL issue: got slot%0d 0x%08h pc 0x%08h, expected slot%0d 0x%08h pc 0x%08h",
                    slot, instr, pc, e.slot, e.instr, e.pc);
    end
  endtask

  // Monitor: every accepted issue is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && issue_ready) begin
      if (issue0_valid) check_issue(1'b0, issue0_instr, issue0_pc);
      if (issue1_valid) check_issue(1'b1, issue1_instr, issue1_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    fetch_valid  = 1'b1;
    fetch_instr0 = i0;
    fetch_instr1 = i1;
    fetch_pc     = pc;
  endtask

  task automatic expect_issue(input logic slot, input logic [31:0] instr, input logic [31:0] pc);
    exp_q.push_back('{slot: slot, instr: instr, pc: pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_instr0 = '0; fetch_instr1 = '0;
    fetch_pc = '0; issue_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_v0", 32'(issue0_valid), 32'd0);
    chk("rst_v1", 32'(issue1_valid), 32'd0);
    chk("rst_i0_instr", issue0_instr, 32'd0);
    chk("rst_i1_pc", issue1_pc, 32'd0);
    step(); rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("idle_v0", 32'(issue0_valid), 32'd0);

    // Independent pair issues together
    step(); drive_pair(ADD3, ADD7, 32'h0);
    expect_issue(1'b0, ADD3, 32'h0); expect_issue(1'b1, ADD7, 32'h4);
    step(); fetch_valid = 1'b0;
    @(negedge clk); chk("pair_v1", 32'(issue1_valid), 32'd1);
    step();
    @(negedge clk);
    chk("pair_drained_v0", 32'(issue0_valid), 32'd0);
    chk("pair_drained_ready", 32'(fetch_ready), 32'd1);

    // RAW inside the pair
    step(); drive_pair(ADD3, ADD5, 32'h0);
    expect_issue(1'b0, ADD3, 32'h0); expect_issue(1'b0, ADD5, 32'h4);
    step(); fetch_valid = 1'b0;
    @(negedge clk); chk("raw_v1", 32'(issue1_valid), 32'd0);
    step();
    @(negedge clk); chk("raw_second_v0", 32'(issue0_valid), 32'd1);
    chk("raw_second_pc", issue0_pc, 32'h4);
    step();

    // Load-use stall
    step(); drive_pair(LW2, NOP, 32'h10);
    expect_issue(1'b0, LW2, 32'h10); expect_issue(1'b1, NOP, 32'h14);
    step(); drive_pair(ADDU2, NOP, 32'h18);
    expect_issue(1'b0, ADDU2, 32'h18); expect_issue(1'b1, NOP, 32'h1C);
    @(negedge clk); chk("lu_pair_v1", 32'(issue1_valid), 32'd1);
    step(); fetch_valid = 1'b0;
    @(negedge clk); chk("lu_stall_v0", 32'(issue0_valid), 32'd0);
    step();
    @(negedge clk); chk("lu_release_v1", 32'(issue1_valid), 32'd1);
    step();

    // Two memory ops
    step(); drive_pair(LW2, SW3, 32'h40);
    expect_issue(1'b0, LW2, 32'h40); expect_issue(1'b0, SW3, 32'h44);
    step(); fetch_valid = 1'b0;
    @(negedge clk); chk("mem_v1", 32'(issue1_valid), 32'd0);
    step();
    @(negedge clk); chk("mem_second_v0", 32'(issue0_valid), 32'd1);
    step();

    // Branch in slot 1 waits for slot 0
    step(); drive_pair(NOP, BEQ, 32'h80);
    expect_issue(1'b0, NOP, 32'h80); expect_issue(1'b0, BEQ, 32'h84);
    step(); fetch_valid = 1'b0;
    @(negedge clk); chk("br_slot1_v1", 32'(issue1_valid), 32'd0);
    step();
    @(negedge clk); chk("br_slot0_instr", issue0_instr, BEQ);
    step();

    // Backpressure until full
    step(); issue_ready = 1'b0; drive_pair(ADD3, ADD7, 32'h200);
    expect_issue(1'b0, ADD3, 32'h200); expect_issue(1'b1, ADD7, 32'h204);
    step(); drive_pair(ADD9, ADD10, 32'h208);
    expect_issue(1'b0, ADD9, 32'h208); expect_issue(1'b1, ADD10, 32'h20C);
    step(); fetch_valid = 1'b0;
    @(negedge clk);
    chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("full_hold_i0", issue0_instr, ADD3);
    step();
    @(negedge clk); chk("full_hold_i1_pc", issue1_pc, 32'h204);
    step(); issue_ready = 1'b1;
    @(negedge clk); chk("pop_no_same_cycle_ready", 32'(fetch_ready), 32'd0);
    step();
    @(negedge clk); chk("drain_v1", 32'(issue1_valid), 32'd1);
    step();
    @(negedge clk); chk("drain_empty_v0", 32'(issue0_valid), 32'd0);

    // Flush at count=3 with an armed load-use window
    step(); drive_pair(LW2, ADDU2, 32'h300);
    expect_issue(1'b0, LW2, 32'h300);
    step(); drive_pair(ADD3, ADD7, 32'h308);
    @(negedge clk); chk("flush_pre_v1", 32'(issue1_valid), 32'd0);
    step(); flush = 1'b1; issue_ready = 1'b0; drive_pair(ADD9, ADD10, 32'h310);
    @(negedge clk);
    chk("flush_v0", 32'(issue0_valid), 32'd0);
    chk("flush_v1", 32'(issue1_valid), 32'd0);
    step(); flush = 1'b0; drive_pair(ADDU2, NOP, 32'h320);
    expect_issue(1'b0, ADDU2, 32'h320); expect_issue(1'b1, NOP, 32'h324);
    @(negedge clk);
    chk("post_flush_empty_v0", 32'(issue0_valid), 32'd0);
    chk("post_flush_ready", 32'(fetch_ready), 32'd1);
    step(); fetch_valid = 1'b0; issue_ready = 1'b1;
    @(negedge clk);
    chk("flush_lu_cleared_v0", 32'(issue0_valid), 32'd1);
    chk("flush_lu_cleared_v1", 32'(issue1_valid), 32'd1);
    step();
    @(negedge clk); chk("end_empty_v0", 32'(issue0_valid), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
